// File: rtl/submaster_rd_rr_arb.sv
// Round-robin read-channel arbiter for eight AXI submasters.
// One submaster owns the shared read path per transfer. A watchdog aborts a
// transfer whose xfer_done never arrives and records the owner on sticky
// error status. All outputs are decoded from registers only.
module submaster_rd_rr_arb #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned TMR_W          = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] start,
  input  logic [7:0] xfer_done,
  input  logic       err_clr,
  output logic [7:0] grant,
  output logic [7:0] processing,
  output logic [7:0] abort,
  output logic       timeout_err,
  output logic [2:0] err_id,
  output logic [2:0] owner_id
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    WAIT  = 2'd2,
    ABORT = 2'd3
  } state_e;

  // A zero timeout disables the watchdog; the terminal count is then unused.
  localparam bit          WDOG_EN  = (TIMEOUT_CYCLES != 0);
  localparam int unsigned LAST_INT = WDOG_EN ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [TMR_W-1:0] TMR_LAST = LAST_INT[TMR_W-1:0];

  state_e           state_q, state_d;
  logic [2:0]       owner_q, owner_d;
  logic [2:0]       rr_ptr_q, rr_ptr_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             timeout_err_q;
  logic [2:0]       err_id_q;

  // Requests rotated so that bit 0 is the submaster at rr_ptr.
  logic [7:0] start_rot;
  logic [2:0] rr_off;
  logic [2:0] rr_sel;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_rot
      assign start_rot[gi] = start[rr_ptr_q + 3'(gi)];
    end
  endgenerate

  // Lowest set bit of the rotated vector is the first requester at/after rr_ptr.
  always_comb begin
    rr_off = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (start_rot[i]) rr_off = 3'(i);
    end
    rr_sel = rr_ptr_q + rr_off;
  end

  // Next-state logic: arbitration, grant, supervised wait and abort.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    tmr_d    = tmr_q;
    unique case (state_q)
      IDLE: begin
        if (|start) begin
          owner_d = rr_sel;
          tmr_d   = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        // xfer_done is deliberately not looked at here.
        state_d = WAIT;
      end
      WAIT: begin
        // Done has priority over an expiry in the same cycle.
        if (xfer_done[owner_q]) begin
          state_d  = IDLE;
          rr_ptr_d = owner_q + 3'd1;
        end else if (WDOG_EN && (tmr_q == TMR_LAST)) begin
          state_d  = ABORT;
          rr_ptr_d = owner_q + 3'd1;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      ABORT: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, owner, pointer and watchdog registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      owner_q  <= 3'd0;
      rr_ptr_q <= 3'd0;
      tmr_q    <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      tmr_q    <= tmr_d;
    end
  end

  // Sticky error flag and id; a set in ABORT beats a simultaneous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timeout_err_q <= 1'b0;
      err_id_q      <= 3'd0;
    end else if (state_q == ABORT) begin
      timeout_err_q <= 1'b1;
      err_id_q      <= owner_q;
    end else if (err_clr) begin
      timeout_err_q <= 1'b0;
    end
  end

  logic [7:0] owner_oh;
  assign owner_oh = 8'd1 << owner_q;

  assign grant       = (state_q == GRANT) ? owner_oh : 8'd0;
  assign processing  = ((state_q == GRANT) || (state_q == WAIT)) ? owner_oh : 8'd0;
  assign abort       = (state_q == ABORT) ? owner_oh : 8'd0;
  assign timeout_err = timeout_err_q;
  assign err_id      = err_id_q;
  assign owner_id    = owner_q;

endmodule

// File: tb/tb_submaster_rd_rr_arb.sv
// Directed bench for submaster_rd_rr_arb (watchdog set to 4 cycles).
// Expected grant indices are queued as requests are driven and checked by a
// monitor whenever a grant pulse appears.
module tb_submaster_rd_rr_arb;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] start;
  logic [7:0] xfer_done;
  logic       err_clr;
  logic [7:0] grant;
  logic [7:0] processing;
  logic [7:0] abort;
  logic       timeout_err;
  logic [2:0] err_id;
  logic [2:0] owner_id;

  int total = 0;
  int bad   = 0;
  int exp_grant_q[$];

  submaster_rd_rr_arb #(
    .TIMEOUT_CYCLES(4),
    .TMR_W(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .xfer_done(xfer_done),
    .err_clr(err_clr),
    .grant(grant),
    .processing(processing),
    .abort(abort),
    .timeout_err(timeout_err),
    .err_id(err_id),
    .owner_id(owner_id)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every grant pulse must match the next queued index.
  always @(negedge clk) begin
    if (!reset && grant !== 8'd0) begin
      if (exp_grant_q.size() == 0) begin
        check("grant_unexpected", grant, 8'd0);
      end else begin
        int idx;
        idx = exp_grant_q.pop_front();
        check("grant_order", grant, 8'(8'd1 << idx));
        $display("grant observed=%h expected_idx=%0d t=%0t", grant, idx, $time);
      end
    end
  end

  initial begin
    reset     = 1'b1;
    start     = 8'd0;
    xfer_done = 8'd0;
    err_clr   = 1'b0;
    step();
    step();
    // Reset state
    check("rst_grant", grant, 8'd0);
    check("rst_processing", processing, 8'd0);
    check("rst_abort", abort, 8'd0);
    check("rst_timeout_err", {7'd0, timeout_err}, 8'd0);
    check("rst_err_id", {5'd0, err_id}, 8'd0);
    check("rst_owner_id", {5'd0, owner_id}, 8'd0);
    reset = 1'b0;
    step();

    // Single request from submaster 2
    start = 8'h04;
    exp_grant_q.push_back(2);
    step();
    check("single_grant", grant, 8'h04);
    check("single_proc_g", processing, 8'h04);
    check("single_owner", {5'd0, owner_id}, 8'd2);
    step();
    check("single_grant_gone", grant, 8'h00);
    check("single_proc_w", processing, 8'h04);
    start     = 8'h00;
    xfer_done = 8'h04;
    step();
    check("single_release", processing, 8'h00);
    check("single_owner_hold", {5'd0, owner_id}, 8'd2);
    xfer_done = 8'h00;

    // Asynchronous reset during WAIT
    start = 8'h10;
    exp_grant_q.push_back(4);
    step();
    step();
    check("rstw_proc_before", processing, 8'h10);
    start = 8'h00;
    #2;
    reset = 1'b1;
    #1;
    check("rstw_proc", processing, 8'h00);
    check("rstw_abort", abort, 8'h00);
    reset = 1'b0;
    step();

    // Fairness with all requesting: 0..7 then 0, three cycles apart
    start = 8'hFF;
    for (int k = 0; k < 9; k++) exp_grant_q.push_back(k % 8);
    for (int k = 0; k < 9; k++) begin
      step();
      check($sformatf("fair_proc_%0d", k), processing, 8'(8'd1 << (k % 8)));
      step();
      xfer_done = 8'(8'd1 << (k % 8));
      if (k == 8) start = 8'h00;
      step();
      xfer_done = 8'h00;
    end

    // Pointer wrap: owner 5 completes, then 8'h21 grants 0 before 5
    start = 8'h20;
    exp_grant_q.push_back(5);
    step();
    step();
    xfer_done = 8'h20;
    start     = 8'h21;
    exp_grant_q.push_back(0);
    exp_grant_q.push_back(5);
    step();
    xfer_done = 8'h00;
    step();
    check("wrap_owner0", {5'd0, owner_id}, 8'd0);
    step();
    xfer_done = 8'h01;
    step();
    xfer_done = 8'h00;
    step();
    check("wrap_owner5", {5'd0, owner_id}, 8'd5);
    step();
    xfer_done = 8'h20;
    start     = 8'h00;
    step();
    xfer_done = 8'h00;

    // Timeout on submaster 7 with a stray non-owner done and owner start drop
    start = 8'h80;
    exp_grant_q.push_back(7);
    step();
    start     = 8'h00;
    xfer_done = 8'h01;
    for (int w = 1; w <= 4; w++) begin
      step();
      check($sformatf("to_wait_proc_%0d", w), processing, 8'h80);
      check($sformatf("to_wait_abort_%0d", w), abort, 8'h00);
    end
    xfer_done = 8'h00;
    step();
    check("to_abort", abort, 8'h80);
    check("to_abort_proc", processing, 8'h00);
    check("to_err_not_yet", {7'd0, timeout_err}, 8'd0);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("to_err_set_wins", {7'd0, timeout_err}, 8'd1);
    check("to_err_id", {5'd0, err_id}, 8'd7);
    check("to_abort_gone", abort, 8'h00);

    // rr_ptr wrapped to 0: 8'h81 must grant 0; done on the 4th WAIT cycle wins
    start = 8'h81;
    exp_grant_q.push_back(0);
    step();
    check("sim_owner", {5'd0, owner_id}, 8'd0);
    start = 8'h00;
    for (int w = 1; w <= 4; w++) step();
    xfer_done = 8'h01;
    step();
    xfer_done = 8'h00;
    check("sim_abort", abort, 8'h00);
    check("sim_proc", processing, 8'h00);
    step();
    check("sim_abort_late", abort, 8'h00);
    check("sim_err_unchanged", {7'd0, timeout_err}, 8'd1);

    // err_clr clears the sticky flag
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("clr_err", {7'd0, timeout_err}, 8'd0);
    check("clr_err_id_hold", {5'd0, err_id}, 8'd7);

    // rr_ptr now 1: 8'h81 grants 7
    start = 8'h81;
    exp_grant_q.push_back(7);
    step();
    check("ptr1_owner", {5'd0, owner_id}, 8'd7);
    start = 8'h00;
    step();
    xfer_done = 8'h80;
    step();
    xfer_done = 8'h00;
    step();

    check("grants_outstanding", 8'(exp_grant_q.size()), 8'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
